// File: rtl/wb_ram_responder_if.sv
// Wishbone B4 pipelined bus bundle between an initiator and the RAM responder.
// Clock and reset are kept outside as plain ports of the modules using it.
interface wb_ram_responder_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic        wb_stb_i;
    logic        wb_ack_o;
    logic        wb_cyc_i;
    logic        wb_stall_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o, wb_stall_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o, wb_stall_o
    );
endinterface

// File: rtl/wb_ram_responder.sv
// Pipelined Wishbone B4 responder in front of a single-port 32-bit word RAM.
// One transaction in flight, WAIT_CYCLES extra cycles before the ack pulse.
module wb_ram_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 0
) (
    input logic               clk_i,
    input logic               rst_i,
    wb_ram_responder_if.slave wb
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_t;

    localparam int         DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t                r_state;
    state_t                w_nextState;
    logic [3:0]            r_count;
    logic [3:0]            w_nextCount;
    logic                  w_accept;
    logic                  w_enterAck;

    logic [ADDR_WIDTH-1:0] r_wordAdr;
    logic [31:0]           r_dat;
    logic                  r_we;
    logic [3:0]            r_sel;

    logic [ADDR_WIDTH-1:0] w_accWordAdr;
    logic [31:0]           w_accDat;
    logic                  w_accWe;
    logic [3:0]            w_accSel;

    logic [31:0]           r_rdata;
    logic [31:0]           r_mem [DEPTH];

    logic                  w_unusedAdrBits;

    assign w_unusedAdrBits = ^{wb.wb_adr_i[31:ADDR_WIDTH+2], wb.wb_adr_i[1:0]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_count <= 4'd0;
        end else begin
            r_state <= w_nextState;
            r_count <= w_nextCount;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextCount = r_count;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (wb.wb_cyc_i && wb.wb_stb_i) begin
                    w_accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        w_nextState = ST_ACK;
                    end else begin
                        w_nextState = ST_WAIT;
                        w_nextCount = WAIT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (!wb.wb_cyc_i) begin
                    w_nextState = ST_IDLE;
                end else if (r_count == 4'd0) begin
                    w_nextState = ST_ACK;
                end else begin
                    w_nextCount = r_count - 4'd1;
                end
            end
            ST_ACK: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // With zero wait states the RAM is accessed on the accept edge itself,
    // so the request fields come straight from the bus rather than the latches.
    assign w_accWordAdr = (r_state == ST_IDLE) ? wb.wb_adr_i[ADDR_WIDTH+1:2] : r_wordAdr;
    assign w_accDat     = (r_state == ST_IDLE) ? wb.wb_dat_i : r_dat;
    assign w_accWe      = (r_state == ST_IDLE) ? wb.wb_we_i  : r_we;
    assign w_accSel     = (r_state == ST_IDLE) ? wb.wb_sel_i : r_sel;
    assign w_enterAck   = !rst_i && (w_nextState == ST_ACK);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wordAdr <= '0;
            r_dat     <= 32'd0;
            r_we      <= 1'b0;
            r_sel     <= 4'd0;
        end else if (w_accept) begin
            r_wordAdr <= wb.wb_adr_i[ADDR_WIDTH+1:2];
            r_dat     <= wb.wb_dat_i;
            r_we      <= wb.wb_we_i;
            r_sel     <= wb.wb_sel_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_enterAck && w_accWe) begin
            for (int k = 0; k < 4; k++) begin
                if (w_accSel[k]) begin
                    r_mem[w_accWordAdr][8*k +: 8] <= w_accDat[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rdata <= 32'd0;
        end else if (w_enterAck && !w_accWe) begin
            r_rdata <= r_mem[w_accWordAdr];
        end
    end

    assign wb.wb_dat_o   = r_rdata;
    assign wb.wb_ack_o   = (r_state == ST_ACK);
    assign wb.wb_stall_o = (r_state != ST_IDLE);

endmodule

// File: tb/tb_wb_ram_responder.sv
// Directed bench for wb_ram_responder: one zero-wait and one three-wait instance
// share the request lines and are selected by their own cyc signal.
module tb_wb_ram_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] adr = 32'd0;
    logic [31:0] dat = 32'd0;
    logic        we  = 1'b0;
    logic [3:0]  sel = 4'd0;
    logic        stb = 1'b0;
    logic        cyc0 = 1'b0;
    logic        cyc3 = 1'b0;

    int assertCount = 0;
    int failCount   = 0;

    wb_ram_responder_if bus0 ();
    wb_ram_responder_if bus3 ();

    assign bus0.wb_adr_i = adr;
    assign bus0.wb_dat_i = dat;
    assign bus0.wb_we_i  = we;
    assign bus0.wb_sel_i = sel;
    assign bus0.wb_stb_i = stb;
    assign bus0.wb_cyc_i = cyc0;
    assign bus3.wb_adr_i = adr;
    assign bus3.wb_dat_i = dat;
    assign bus3.wb_we_i  = we;
    assign bus3.wb_sel_i = sel;
    assign bus3.wb_stb_i = stb;
    assign bus3.wb_cyc_i = cyc3;

    wb_ram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
        .clk_i (clk),
        .rst_i (rst),
        .wb    (bus0.slave)
    );

    wb_ram_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) dut3 (
        .clk_i (clk),
        .rst_i (rst),
        .wb    (bus3.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete transaction; returns data seen with the ack, the number of
    // cycles between acceptance and ack, and how many sampled cycles had stall high.
    task automatic applyStimulus(input bit slow, input bit weIn, input logic [31:0] a,
                                 input logic [31:0] d, input logic [3:0] s,
                                 output logic [31:0] rdata, output int lat, output int stallCycles);
        bit done;
        @(negedge clk);
        adr = a;
        dat = d;
        we  = weIn;
        sel = s;
        stb = 1'b1;
        if (slow) cyc3 = 1'b1;
        else      cyc0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        stb = 1'b0;
        lat = 0;
        stallCycles = 0;
        rdata = 32'd0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (slow ? bus3.wb_stall_o : bus0.wb_stall_o) stallCycles++;
            if (slow ? bus3.wb_ack_o : bus0.wb_ack_o) begin
                rdata = slow ? bus3.wb_dat_o : bus0.wb_dat_o;
                done = 1'b1;
            end else begin
                lat++;
                @(negedge clk);
            end
        end
        if (!done) checkOutput("ackTimeout", 32'd0, 32'd1);
        cyc0 = 1'b0;
        cyc3 = 1'b0;
    endtask

    logic [31:0] rd;
    int          lat;
    int          stc;
    logic [9:0]  ackPat;
    logic [9:0]  stallPat;
    logic        anyAck;
    logic        anyStall;

    initial begin
        #1 rst = 1'b1;
        #2;
        checkOutput("rstAck0",   {31'd0, bus0.wb_ack_o},   32'd0);
        checkOutput("rstStall0", {31'd0, bus0.wb_stall_o}, 32'd0);
        checkOutput("rstDat0",   bus0.wb_dat_o,            32'd0);
        checkOutput("rstAck3",   {31'd0, bus3.wb_ack_o},   32'd0);
        checkOutput("rstStall3", {31'd0, bus3.wb_stall_o}, 32'd0);
        checkOutput("rstDat3",   bus3.wb_dat_o,            32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, lat, stc);
        checkOutput("w0Lat",   lat, 32'd0);
        checkOutput("w0Stall", stc, 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h10, 32'd0, 4'hF, rd, lat, stc);
        checkOutput("r0Data",  rd,  32'hDEADBEEF);
        checkOutput("r0Lat",   lat, 32'd0);
        checkOutput("r0Stall", stc, 32'd1);
        @(negedge clk);
        checkOutput("idleStall0", {31'd0, bus0.wb_stall_o}, 32'd0);
        checkOutput("idleAck0",   {31'd0, bus0.wb_ack_o},   32'd0);

        applyStimulus(1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, rd, lat, stc);
        checkOutput("writeKeepsDat", rd, 32'hDEADBEEF);
        applyStimulus(1'b0, 1'b1, 32'h20, 32'h000000AA, 4'h1, rd, lat, stc);
        applyStimulus(1'b0, 1'b0, 32'h20, 32'd0, 4'h1, rd, lat, stc);
        checkOutput("lane0Data", rd, 32'h112233AA);
        applyStimulus(1'b0, 1'b1, 32'h22, 32'h0000BEEF, 4'h3, rd, lat, stc);
        applyStimulus(1'b0, 1'b0, 32'h20, 32'd0, 4'h0, rd, lat, stc);
        checkOutput("halfData", rd, 32'h1122BEEF);
        applyStimulus(1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, rd, lat, stc);
        checkOutput("sel0Lat", lat, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h20, 32'd0, 4'hF, rd, lat, stc);
        checkOutput("sel0Data", rd, 32'h1122BEEF);

        applyStimulus(1'b0, 1'b1, 32'h00001004, 32'h12345678, 4'hF, rd, lat, stc);
        applyStimulus(1'b0, 1'b0, 32'h00000004, 32'd0, 4'hF, rd, lat, stc);
        checkOutput("aliasData", rd, 32'h12345678);

        // Strobe without a bus cycle must be ignored by both instances.
        @(negedge clk);
        adr = 32'h10; we = 1'b1; dat = 32'h0BADF00D; sel = 4'hF; stb = 1'b1;
        anyAck = 1'b0; anyStall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            anyAck   = anyAck   | bus0.wb_ack_o   | bus3.wb_ack_o;
            anyStall = anyStall | bus0.wb_stall_o | bus3.wb_stall_o;
        end
        stb = 1'b0;
        checkOutput("noCycAck",   {31'd0, anyAck},   32'd0);
        checkOutput("noCycStall", {31'd0, anyStall}, 32'd0);
        checkOutput("noCycDat",   bus0.wb_dat_o,     32'h12345678);
        applyStimulus(1'b0, 1'b0, 32'h10, 32'd0, 4'hF, rd, lat, stc);
        checkOutput("noCycMem", rd, 32'hDEADBEEF);

        applyStimulus(1'b1, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, rd, lat, stc);
        checkOutput("w3Lat",   lat, 32'd3);
        checkOutput("w3Stall", stc, 32'd4);

        // Strobe held high through the stall: second accept only after the ack cycle.
        @(negedge clk);
        adr = 32'h40; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc3 = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ackPat[i]   = bus3.wb_ack_o;
            stallPat[i] = bus3.wb_stall_o;
            if (i == 3) checkOutput("heldData", bus3.wb_dat_o, 32'hCAFEF00D);
            if (i == 8) begin
                stb  = 1'b0;
                cyc3 = 1'b0;
            end
        end
        checkOutput("heldAckPat",   {22'd0, ackPat},   32'h108);
        checkOutput("heldStallPat", {22'd0, stallPat}, 32'h1EF);

        applyStimulus(1'b1, 1'b1, 32'h30, 32'h00000000, 4'hF, rd, lat, stc);
        @(negedge clk);
        adr = 32'h30; we = 1'b1; dat = 32'h55; sel = 4'hF; stb = 1'b1; cyc3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        stb = 1'b0;
        anyAck = bus3.wb_ack_o;
        @(posedge clk);
        @(negedge clk);
        cyc3 = 1'b0;
        anyAck = anyAck | bus3.wb_ack_o;
        @(negedge clk);
        checkOutput("abortStall", {31'd0, bus3.wb_stall_o}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            anyAck = anyAck | bus3.wb_ack_o;
            @(negedge clk);
        end
        checkOutput("abortNoAck", {31'd0, anyAck}, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h30, 32'd0, 4'hF, rd, lat, stc);
        checkOutput("abortMem", rd, 32'h00000000);

        applyStimulus(1'b1, 1'b0, 32'h40, 32'd0, 4'hF, rd, lat, stc);
        checkOutput("preRstData", rd, 32'hCAFEF00D);
        @(negedge clk);
        adr = 32'h30; we = 1'b0; stb = 1'b1; cyc3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        stb = 1'b0;
        checkOutput("midWaitStall", {31'd0, bus3.wb_stall_o}, 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("asyncRstAck3",   {31'd0, bus3.wb_ack_o},   32'd0);
        checkOutput("asyncRstStall3", {31'd0, bus3.wb_stall_o}, 32'd0);
        checkOutput("asyncRstDat3",   bus3.wb_dat_o,            32'd0);
        checkOutput("asyncRstDat0",   bus0.wb_dat_o,            32'd0);
        @(negedge clk);
        rst  = 1'b0;
        cyc3 = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h40, 32'd0, 4'hF, rd, lat, stc);
        checkOutput("postRstData", rd,  32'hCAFEF00D);
        checkOutput("postRstLat",  lat, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
